servant_uart_loader: RTL and testbench

Serial boot loader for the servant SoC: a UART receiver (8N1) feeding a Wishbone initiator that writes a host-supplied program image into servant RAM while the CPU is held in reset. It drives the same Wishbone write interface that the CPU data bus drives into the arbiter and RAM. The CPU reset is released only after the last word is acknowledged.

---
 rtl/servant_uart_loader.sv | 191 +++++++++++++++++++
 tb/tb_servant_uart_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_uart_loader.sv
// Serial boot loader: 8N1 UART receiver feeding a Wishbone write initiator that
// fills servant RAM from a length-prefixed image while holding the CPU in reset.
module servant_uart_loader #(
   parameter int CLKS_PER_BIT = 104,
   parameter int MEMSIZE      = 8192
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_rx,
   output logic        o_cpu_rst,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic        i_wb_ack,
   output logic        o_done,
   output logic        o_err
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [31:0]   ADR_MASK = 32'(MEMSIZE - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {LD_HDR0, LD_HDR1, LD_DATA, LD_DONE} ld_state_t;

   logic          rx_meta;
   logic          rx_sync;
   logic          rx_prev;
   rx_state_t     rx_state;
   rx_state_t     rx_next;
   logic [CW-1:0] clk_cnt;
   logic [3:0]    bit_idx;
   logic [7:0]    rx_shift;
   logic          byte_stb;
   logic          cnt_clr;
   logic          bit_shift;
   logic          stb_set;
   logic          ferr_set;
   logic          tick_half;
   logic          tick_full;

   ld_state_t     ld_state;
   ld_state_t     ld_next;
   logic [15:0]   word_cnt;
   logic [15:0]   word_idx;
   logic [1:0]    byte_pos;
   logic [23:0]   word_lo;
   logic          wb_busy;
   logic          data_en;
   logic          word_ready;
   logic          word_load;
   logic          word_skip;
   logic          hdr_zero;

   // rx_prev lets the idle state see a genuine high-to-low transition, so a line
   // left low after a framing error cannot re-arm the receiver.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign tick_half = (clk_cnt == CNT_HALF);
   assign tick_full = (clk_cnt == CNT_FULL);

   always_comb begin
      rx_next   = rx_state;
      cnt_clr   = 1'b0;
      bit_shift = 1'b0;
      stb_set   = 1'b0;
      ferr_set  = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            cnt_clr = 1'b1;
            if (rx_prev && !rx_sync) rx_next = RX_START;
         end
         RX_START: begin
            if (tick_half) begin
               cnt_clr = 1'b1;
               rx_next = rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (tick_full) begin
               cnt_clr   = 1'b1;
               bit_shift = 1'b1;
               if (bit_idx == 4'd7) rx_next = RX_STOP;
            end
         end
         default: begin
            if (tick_full) begin
               cnt_clr = 1'b1;
               rx_next = RX_IDLE;
               if (rx_sync) stb_set = 1'b1;
               else         ferr_set = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_state <= RX_IDLE;
         clk_cnt  <= '0;
         bit_idx  <= '0;
         rx_shift <= '0;
         byte_stb <= 1'b0;
      end else begin
         rx_state <= rx_next;
         byte_stb <= stb_set;
         clk_cnt  <= cnt_clr ? '0 : clk_cnt + 1'b1;
         if (rx_state == RX_IDLE) begin
            bit_idx <= '0;
         end else if (bit_shift) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
         end
      end
   end

   // A write acked on this edge frees the buffer, so a 4th byte landing on that
   // same edge is accepted rather than counted as an overrun.
   assign wb_busy    = o_wb_cyc && !i_wb_ack;
   assign data_en    = byte_stb && (ld_state == LD_DATA) && (word_idx != word_cnt);
   assign word_ready = data_en && (byte_pos == 2'd3);
   assign word_load  = word_ready && !wb_busy;
   assign word_skip  = word_ready && wb_busy;
   assign hdr_zero   = (rx_shift == 8'd0) && (word_cnt[7:0] == 8'd0);

   always_comb begin
      ld_next = ld_state;
      case (ld_state)
         LD_HDR0: if (byte_stb) ld_next = LD_HDR1;
         LD_HDR1: if (byte_stb) ld_next = hdr_zero ? LD_DONE : LD_DATA;
         LD_DATA: if ((word_idx == word_cnt) && !wb_busy) ld_next = LD_DONE;
         default: ld_next = LD_DONE;
      endcase
   end

   // word_idx advances when a word is issued or dropped, so the address of the
   // buffered word is fixed at load time and an overrun still consumes an index.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ld_state <= LD_HDR0;
         word_cnt <= '0;
         word_idx <= '0;
         byte_pos <= '0;
         word_lo  <= '0;
         o_wb_cyc <= 1'b0;
         o_wb_adr <= '0;
         o_wb_dat <= '0;
         o_err    <= 1'b0;
      end else begin
         ld_state <= ld_next;
         if (ferr_set || word_skip) o_err <= 1'b1;
         if (byte_stb && (ld_state == LD_HDR0)) word_cnt[7:0]  <= rx_shift;
         if (byte_stb && (ld_state == LD_HDR1)) word_cnt[15:8] <= rx_shift;
         if (data_en) begin
            byte_pos <= byte_pos + 1'b1;
            case (byte_pos)
               2'd0:    word_lo[7:0]   <= rx_shift;
               2'd1:    word_lo[15:8]  <= rx_shift;
               2'd2:    word_lo[23:16] <= rx_shift;
               default: ;
            endcase
         end
         if (o_wb_cyc && i_wb_ack) o_wb_cyc <= 1'b0;
         if (word_load) begin
            o_wb_cyc <= 1'b1;
            o_wb_adr <= {14'd0, word_idx, 2'b00} & ADR_MASK;
            o_wb_dat <= {rx_shift, word_lo};
         end
         if (word_ready) word_idx <= word_idx + 1'b1;
      end
   end

   assign o_done    = (ld_state == LD_DONE);
   assign o_cpu_rst = !o_done;
   assign o_wb_sel  = 4'hF;
   assign o_wb_we   = 1'b1;

endmodule

// File: tb/tb_servant_uart_loader.sv
// Scoreboard bench for servant_uart_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares each acknowledged Wishbone write.
`timescale 1ns/1ps
module tb_servant_uart_loader;

   localparam int CPB = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_a = 1'b1;
   logic        rx_b = 1'b1;
   logic        ack_a = 1'b0;
   logic        ack_b = 1'b0;
   logic        ack_en_a = 1'b1;

   logic        cpu_rst_a, cyc_a, we_a, done_a, err_a;
   logic [31:0] adr_a, dat_a;
   logic [3:0]  sel_a;
   logic        cpu_rst_b, cyc_b, we_b, done_b, err_b;
   logic [31:0] adr_b, dat_b;
   logic [3:0]  sel_b;

   int          errors = 0;
   int          checks = 0;
   int          cyc_cnt_a = 0;
   logic [63:0] q_a[$];
   logic [63:0] q_b[$];

   logic [7:0]  basic_img [10] = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                                   8'hEF, 8'hBE, 8'hAD, 8'hDE};
   logic [7:0]  line_img  [10] = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                                   8'h05, 8'h06, 8'h07, 8'h08};

   always #5 clk = ~clk;

   servant_uart_loader #(.CLKS_PER_BIT(CPB), .MEMSIZE(8192)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a), .o_cpu_rst(cpu_rst_a),
      .o_wb_adr(adr_a), .o_wb_dat(dat_a), .o_wb_sel(sel_a), .o_wb_we(we_a),
      .o_wb_cyc(cyc_a), .i_wb_ack(ack_a), .o_done(done_a), .o_err(err_a)
   );

   servant_uart_loader #(.CLKS_PER_BIT(CPB), .MEMSIZE(16)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_b), .o_cpu_rst(cpu_rst_b),
      .o_wb_adr(adr_b), .o_wb_dat(dat_b), .o_wb_sel(sel_b), .o_wb_we(we_b),
      .o_wb_cyc(cyc_b), .i_wb_ack(ack_b), .o_done(done_b), .o_err(err_b)
   );

   // One-cycle-ack responders; dut_a's ack can be withheld.
   always @(posedge clk) begin
      ack_a <= cyc_a && !ack_a && ack_en_a;
      ack_b <= cyc_b && !ack_b;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every acknowledged write is popped against the scoreboard; after the
   // last expected write, completion must be visible one cycle later.
   always @(negedge clk) begin
      logic [63:0] e;
      if (cyc_a) cyc_cnt_a++;
      if (cyc_a && ack_a) begin
         if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a unexpected write: got adr 0x%0h dat 0x%0h, want none", adr_a, dat_a);
         end else begin
            e = q_a.pop_front();
            check("a write adr", adr_a, e[63:32]);
            check("a write dat", dat_a, e[31:0]);
            if (q_a.size() == 0) begin
               @(negedge clk);
               check("a done/cpu_rst after last ack", {done_a, cpu_rst_a}, 2'b10);
            end
         end
      end
      if (cyc_b && ack_b) begin
         if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b unexpected write: got adr 0x%0h dat 0x%0h, want none", adr_b, dat_b);
         end else begin
            e = q_b.pop_front();
            check("b write adr", adr_b, e[63:32]);
            check("b write dat", dat_b, e[31:0]);
            if (q_b.size() == 0) begin
               @(negedge clk);
               check("b done/cpu_rst after last ack", {done_b, cpu_rst_b}, 2'b10);
            end
         end
      end
   end

   task automatic send_byte(input bit to_b, input logic [7:0] b, input logic stop = 1'b1);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (to_b) rx_b = frame[i];
         else      rx_a = frame[i];
         repeat (CPB) @(negedge clk);
      end
      if (to_b) rx_b = 1'b1;
      else      rx_a = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic wait_done(input bit to_b, input string name);
      int n;
      n = 0;
      while (!(to_b ? done_b : done_a) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(name, to_b ? done_b : done_a, 1'b1);
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int c0;
      logic [7:0] v;

      // Reset state
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      check("reset cpu_rst", cpu_rst_a, 1'b1);
      check("reset cyc", cyc_a, 1'b0);
      check("reset done", done_a, 1'b0);
      check("reset err", err_a, 1'b0);
      check("reset adr", adr_a, 32'h0);
      check("reset dat", dat_a, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic two-word load
      q_a.push_back({32'h0, 32'h11223344});
      q_a.push_back({32'h4, 32'hDEADBEEF});
      for (int i = 0; i < 10; i++) send_byte(1'b0, basic_img[i]);
      wait_done(1'b0, "basic done");
      check("basic cpu_rst", cpu_rst_a, 1'b0);
      check("basic err", err_a, 1'b0);
      check("basic all writes seen", q_a.size(), 0);

      // Address wrap with MEMSIZE=16, five words
      do_reset();
      q_b.push_back({32'h0, 32'h03020100});
      q_b.push_back({32'h4, 32'h13121110});
      q_b.push_back({32'h8, 32'h23222120});
      q_b.push_back({32'hC, 32'h33323130});
      q_b.push_back({32'h0, 32'h43424140});
      send_byte(1'b1, 8'h05);
      send_byte(1'b1, 8'h00);
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 4; j++) begin
            v = 8'((k << 4) | j);
            send_byte(1'b1, v);
         end
      end
      wait_done(1'b1, "wrap done");
      check("wrap all writes seen", q_b.size(), 0);
      check("wrap err", err_b, 1'b0);

      // Empty image
      do_reset();
      c0 = cyc_cnt_a;
      send_byte(1'b0, 8'h00);
      check("empty not done after 1 byte", done_a, 1'b0);
      send_byte(1'b0, 8'h00);
      check("empty done", done_a, 1'b1);
      check("empty cpu_rst", cpu_rst_a, 1'b0);
      check("empty no cyc", cyc_cnt_a - c0, 0);

      // Line errors: glitch, framing error, then a normal load
      do_reset();
      rx_a = 1'b0;
      repeat (2) @(negedge clk);
      rx_a = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch no err", err_a, 1'b0);
      send_byte(1'b0, 8'h5A, 1'b0);
      check("framing err", err_a, 1'b1);
      q_a.push_back({32'h0, 32'h04030201});
      q_a.push_back({32'h4, 32'h08070605});
      for (int i = 0; i < 10; i++) send_byte(1'b0, line_img[i]);
      wait_done(1'b0, "line errors done");
      check("line errors all writes seen", q_a.size(), 0);

      // Overrun: ack withheld across the second word
      do_reset();
      ack_en_a = 1'b0;
      q_a.push_back({32'h0, 32'hA3A2A1A0});
      send_byte(1'b0, 8'h02);
      send_byte(1'b0, 8'h00);
      send_byte(1'b0, 8'hA0);
      send_byte(1'b0, 8'hA1);
      send_byte(1'b0, 8'hA2);
      send_byte(1'b0, 8'hA3);
      check("overrun cyc held", cyc_a, 1'b1);
      check("overrun no err yet", err_a, 1'b0);
      send_byte(1'b0, 8'hB0);
      send_byte(1'b0, 8'hB1);
      send_byte(1'b0, 8'hB2);
      send_byte(1'b0, 8'hB3);
      check("overrun err", err_a, 1'b1);
      check("overrun dat stable", dat_a, 32'hA3A2A1A0);
      check("overrun adr stable", adr_a, 32'h0);
      check("overrun not done", done_a, 1'b0);
      ack_en_a = 1'b1;
      wait_done(1'b0, "overrun done");
      check("overrun all writes seen", q_a.size(), 0);

      // Reset abort mid-write
      do_reset();
      ack_en_a = 1'b0;
      send_byte(1'b0, 8'h01);
      send_byte(1'b0, 8'h00);
      send_byte(1'b0, 8'hC0);
      send_byte(1'b0, 8'hC1);
      send_byte(1'b0, 8'hC2);
      send_byte(1'b0, 8'hC3);
      check("abort cyc before reset", cyc_a, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("abort cyc dropped", cyc_a, 1'b0);
      check("abort cpu_rst", cpu_rst_a, 1'b1);
      check("abort adr", adr_a, 32'h0);
      check("abort err", err_a, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      ack_en_a = 1'b1;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
